// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryption core.
// One ciphertext block is accepted over a valid/ready handshake. The core runs
// one inverse-cipher round per clock (standard ordering, not equivalent-inverse)
// and holds the plaintext on a registered valid/ready output. Round keys come
// combinationally from an external key store addressed by round_idx.
module aes_decrypt_iterative (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_KEY   = 4'd10;
  localparam logic [3:0] FIRST_MID  = 4'd9;

  // Inverse S-box, entry 0 in the top byte, row-major by high nibble.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         st, st_next;
  logic [3:0]   rc;
  logic [127:0] state_reg;
  logic [127:0] plaintext_reg;
  logic [127:0] round_out;
  logic         accept;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (0e, 0b, 0d, 09 are all that is needed).
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? x  : 8'h00);
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
  // InvMixColumns unless this is the final round. Byte k = 4*col + row
  // lives at bits [127-8k -: 8].
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] key,
                                             input logic         last);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
    t = t ^ key;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127 - 32*c -: 8];
        a1 = t[119 - 32*c -: 8];
        a2 = t[111 - 32*c -: 8];
        a3 = t[103 - 32*c -: 8];
        t[127 - 32*c -: 32] = {
          gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
          gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
          gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
          gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
        };
      end
    end
    return t;
  endfunction

  assign round_out = inv_round(state_reg, round_key, rc == 4'd0);
  assign accept    = in_valid && in_ready;
  assign plaintext = plaintext_reg;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_next;
  end

  // Next-state and handshake/address outputs; round_idx depends on state and rc only.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    st_next   = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    round_idx = LAST_KEY;
    unique case (st)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) st_next = ROUND;
      end
      ROUND: begin
        round_idx = rc;
        if (rc == 4'd0) st_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_next = IDLE;
      end
      default: st_next = IDLE;
    endcase
  end

  // Round counter and plaintext output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc            <= 4'd0;
      plaintext_reg <= '0;
    end else begin
      case (st)
        IDLE:    if (accept) rc <= FIRST_MID;
        ROUND:   if (rc == 4'd0) plaintext_reg <= round_out;
                 else            rc <= rc - 4'd1;
        default: ;
      endcase
    end
  end

  // Working cipher state.
  // NOTE: deliberately unreset -- it is always loaded on accept before any round reads it.
  always_ff @(posedge clk) begin
    if (accept)           state_reg <= ciphertext ^ round_key;
    else if (st == ROUND) state_reg <= round_out;
  end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Self-checking bench for aes_decrypt_iterative.
// The bench owns the key store (key expansion in plain arithmetic) and a
// forward AES-128 reference built from GF(2^8) math, so random blocks are
// produced by encrypting random plaintext and the DUT must recover it.
module tb_aes_decrypt_iterative;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] ciphertext, round_key, plaintext;
  logic [3:0]   round_idx;

  logic [7:0]   sbox [256];
  logic [127:0] ks   [11];
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clk = ~clk;

  // Key-store model: combinational read addressed by the core.
  assign round_key = (round_idx <= 4'd10) ? ks[round_idx] : '0;

  aes_decrypt_iterative dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .round_idx  (round_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher with the key currently in the key store.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] blk;
    blk = pt ^ ks[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = sbox[blk[127 - 8*(4*c + r) -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = s[r][(c + r) % 4];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = gf_mul(t[0][c], 8'h02) ^ gf_mul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gf_mul(t[1][c], 8'h02) ^ gf_mul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gf_mul(t[2][c], 8'h02) ^ gf_mul(t[3][c], 8'h03);
          s[3][c] = gf_mul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gf_mul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) blk[127 - 8*(4*c + r) -: 8] = s[r][c];
      blk = blk ^ ks[rnd];
    end
    return blk;
  endfunction

  // One complete transaction with optional idle gap before and backpressure after.
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input int pre_gap,
                           input int post_gap, input string tag);
    int n;
    load_key(key);
    repeat (pre_gap) tick();
    in_valid   = 1'b1;
    ciphertext = ct;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check({tag, "_accept"}, 128'(in_ready), 128'd1);
    tick();
    in_valid   = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check({tag, "_latency"}, 128'(n), 128'd10);
    repeat (post_gap) tick();
    check({tag, "_plaintext"}, plaintext, pt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release"}, 128'({out_valid, in_ready}), 128'(2'b01));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0]  seq;
    logic [10:0]  vpat;
    logic [127:0] held;
    logic [127:0] outs [$];
    int           acc_cyc [$];
    int           bad, cyc, blk;
    logic [127:0] key, pt;

    // Forward S-box from multiplicative inverse plus affine map.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    load_key(C1_KEY);

    // Reset values.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0;
    repeat (3) tick();
    check("rst_in_ready",  128'(in_ready),  128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_plaintext", plaintext,       128'd0);
    check("rst_round_idx", 128'(round_idx), 128'd10);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 C.1 with exact round_idx sequence and latency, then backpressure.
    in_valid = 1'b1; ciphertext = C1_CT;
    bad = 0;
    while (!in_ready && bad < 40) begin tick(); bad++; end
    seq = {44'h0, round_idx};
    tick();
    in_valid = 1'b0;
    vpat = '0;
    for (int k = 0; k < 11; k++) begin
      seq  = {seq[43:0], round_idx};
      vpat = {vpat[9:0], out_valid};
      if (k < 10) tick();
    end
    check("c1_round_idx_seq", 128'(seq),  128'h0000_a987_6543_210a);
    check("c1_valid_timing",  128'(vpat), 128'(11'b000_0000_0001));
    check("c1_plaintext",     plaintext,  C1_PT);

    held = plaintext;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin in_valid = 1'b1; ciphertext = B_CT; end
      if (k == 6) in_valid = 1'b0;
      tick();
      if (!out_valid || in_ready || plaintext !== held || round_idx != 4'd10) bad++;
    end
    check("bp_stable", 128'(bad), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));
    repeat (2) tick();
    check("bp_no_accept", 128'({round_idx, in_ready}), 128'({4'd10, 1'b1}));
    check("pt_hold_idle", plaintext, C1_PT);

    // FIPS-197 appendix B.
    run_block(B_KEY, B_CT, B_PT, 0, 0, "fips_b");

    // Back-to-back: C.1 / B alternating with in_valid and out_ready held high.
    load_key(C1_KEY); ciphertext = C1_CT; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; blk = 0;
    while (outs.size() < 4 && cyc < 200) begin
      if (in_ready && in_valid) acc_cyc.push_back(cyc);
      if (out_valid) begin
        outs.push_back(plaintext);
        blk++;
        if (blk < 4) begin
          load_key(blk[0] ? B_KEY : C1_KEY);
          ciphertext = blk[0] ? B_CT : C1_CT;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("b2b_outputs", 128'(outs.size()),    128'd4);
    check("b2b_accepts", 128'(acc_cyc.size()), 128'd4);
    for (int i = 1; i < 4; i++)
      if (i < acc_cyc.size())
        check("b2b_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd12);
    for (int i = 0; i < 4; i++)
      if (i < outs.size())
        check("b2b_plaintext", outs[i], i[0] ? B_PT : C1_PT);

    // Reset in the middle of a block.
    load_key(C1_KEY); in_valid = 1'b1; ciphertext = C1_CT;
    bad = 0;
    while (!in_ready && bad < 40) begin tick(); bad++; end
    tick();
    in_valid = 1'b0;
    bad = 0;
    repeat (5) begin if (out_valid) bad++; tick(); end
    rst = 1'b1;
    tick();
    if (out_valid) bad++;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready",  128'(in_ready),  128'd1);
    check("mid_rst_round_idx", 128'(round_idx), 128'd10);
    check("mid_rst_plaintext", plaintext,       128'd0);
    repeat (20) begin tick(); if (out_valid) bad++; end
    check("mid_rst_no_output", 128'(bad), 128'd0);
    run_block(B_KEY, B_CT, B_PT, 0, 0, "post_rst");

    // Random key/plaintext pairs encrypted by the reference model.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      run_block(key, encrypt(pt), pt, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
